// File: rtl/tick_period_checker_if.sv
// Tick-checker bus: qualification, tick and resync inputs plus the
// measurement/lock/error outputs of the checker.
interface tick_period_checker_if #(
    parameter int CW = 8
);
    logic          i_enable;
    logic          i_tick;
    logic          i_resync;
    logic          o_locked;
    logic [CW-1:0] o_period;
    logic          o_per_valid;
    logic          o_err;
    logic [3:0]    o_err_cnt;

    // Checker side
    modport slave (
        input  i_enable, i_tick, i_resync,
        output o_locked, o_period, o_per_valid, o_err, o_err_cnt
    );

    // Stimulus / monitoring side
    modport master (
        output i_enable, i_tick, i_resync,
        input  o_locked, o_period, o_per_valid, o_err, o_err_cnt
    );
endinterface

// File: rtl/tick_period_checker.sv
// Measures the enabled-cycle interval between successive generator ticks,
// compares it with the expected period, declares lock after LOCK_N good
// periods in a row and flags early or missing ticks while locked.
module tick_period_checker #(
    parameter int PERIOD = 11,
    parameter int CW     = 8,
    parameter int LOCK_N = 3
) (
    input  logic                 i_clk,
    input  logic                 i_clear,
    tick_period_checker_if.slave bus
);
    localparam int            GW       = $clog2(LOCK_N + 1);
    localparam logic [CW-1:0] PERIOD_C = CW'(PERIOD);
    localparam logic [GW-1:0] LOCK_N_C = GW'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_t;

    state_t        r_state,     w_state_nxt;
    logic [CW-1:0] r_cnt,       w_cnt_nxt;
    logic [GW-1:0] r_good,      w_good_nxt;
    logic [CW-1:0] r_period,    w_period_nxt;
    logic          r_per_valid, w_per_valid_nxt;
    logic          r_err,       w_err_nxt;
    logic [3:0]    r_err_cnt,   w_err_cnt_nxt;

    logic [CW-1:0] w_cnt_inc;
    logic [GW-1:0] w_good_inc;
    logic [3:0]    w_err_cnt_inc;
    logic          w_match;

    // Saturating increments and the "interval equals expected" compare
    assign w_cnt_inc     = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    assign w_good_inc    = r_good + 1'b1;
    assign w_err_cnt_inc = (r_err_cnt == 4'hF) ? r_err_cnt : r_err_cnt + 1'b1;
    assign w_match       = (r_cnt == PERIOD_C);

    // Next-state and next-output decode
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_good_nxt      = r_good;
        w_period_nxt    = r_period;
        w_per_valid_nxt = 1'b0;
        w_err_nxt       = 1'b0;
        w_err_cnt_nxt   = r_err_cnt;

        if (bus.i_resync) begin
            // Restart wins over a same-cycle tick; Period and ErrCnt are held.
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_good_nxt  = '0;
        end else if (bus.i_enable) begin
            unique case (r_state)
                IDLE: begin
                    if (bus.i_tick) begin
                        w_cnt_nxt   = CW'(1);
                        w_good_nxt  = '0;
                        w_state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    if (bus.i_tick) begin
                        w_period_nxt    = r_cnt;
                        w_per_valid_nxt = 1'b1;
                        w_cnt_nxt       = CW'(1);
                        if (w_match) begin
                            w_good_nxt = w_good_inc;
                            if (w_good_inc == LOCK_N_C) begin
                                w_state_nxt = LOCKED;
                            end
                        end else begin
                            w_good_nxt = '0;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                LOCKED: begin
                    if (bus.i_tick) begin
                        w_period_nxt    = r_cnt;
                        w_per_valid_nxt = 1'b1;
                        w_cnt_nxt       = CW'(1);
                        if (!w_match) begin
                            // Early tick: the count never exceeds PERIOD here.
                            w_err_nxt     = 1'b1;
                            w_err_cnt_nxt = w_err_cnt_inc;
                            w_good_nxt    = '0;
                            w_state_nxt   = MEASURE;
                        end
                    end else begin
                        // Keep counting past a missing tick so a late one
                        // still reports the full interval.
                        w_cnt_nxt = w_cnt_inc;
                        if (w_match) begin
                            w_err_nxt     = 1'b1;
                            w_err_cnt_nxt = w_err_cnt_inc;
                            w_good_nxt    = '0;
                            w_state_nxt   = MEASURE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_good_nxt  = '0;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge i_clk or posedge i_clear) begin
        if (i_clear) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_good      <= '0;
            r_period    <= '0;
            r_per_valid <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values decoded from the pre-edge state.
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_good      <= w_good_nxt;
            r_period    <= w_period_nxt;
            r_per_valid <= w_per_valid_nxt;
            r_err       <= w_err_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
        end
    end

    assign bus.o_locked    = (r_state == LOCKED);
    assign bus.o_period    = r_period;
    assign bus.o_per_valid = r_per_valid;
    assign bus.o_err       = r_err;
    assign bus.o_err_cnt   = r_err_cnt;
endmodule

// File: doc/tick_period_checker.md
# tick_period_checker

Receive-side companion to the team's reloading down-counter tick generator. Monitors the one-cycle terminal-count pulse stream (`Tick`), measures the number of enabled clock cycles between successive pulses, and checks it against an expected period. Reports the last measured period, a lock indication after consecutive good periods, and a per-event and cumulative error indication. Sits in the same clock domain as the generator and uses the same `Enable` qualification.

## Interface
- `PERIOD`, default 11: expected interval between ticks, in enabled cycles; must be ≥2 and ≤2^CW−2.
- `CW`, default 8: width of the interval counter and of `Period`.
- `LOCK_N`, default 3: number of consecutive matching periods required to enter LOCKED; must be ≥1.

Ports:
- `Clk`, input, 1: clock; all state changes on the rising edge.
- `Clear`, input, 1: reset, asynchronous, active-high.
- `Enable`, input, 1: qualifies cycles; `Tick` is sampled and cycles are counted only when high.
- `Tick`, input, 1: terminal-count pulse from the generator.
- `Resync`, input, 1: synchronous restart to IDLE; acts regardless of `Enable`.
- `Locked`, output, 1: high while in LOCKED.
- `Period`, output, CW: last measured interval.
- `PerValid`, output, 1: one-cycle pulse when `Period` updates.
- `Err`, output, 1: one-cycle pulse on each error event.
- `ErrCnt`, output, 4: saturating count of error events.

## Operation
- States: IDLE, MEASURE, LOCKED. Internal `cnt` (CW bits) and `good` (run counter, 0..LOCK_N).
- IDLE: on enabled `Tick` → `cnt`←1, `good`←0, go MEASURE; no `PerValid`.
- MEASURE/LOCKED, enabled cycle without `Tick`: `cnt`←`cnt`+1, saturating at 2^CW−1.
- MEASURE/LOCKED, enabled `Tick`: `Period`←`cnt`, `PerValid` pulses, `cnt`←1. The tick is **matching** when `cnt`==PERIOD.
  - MEASURE, matching: `good`+1; if this reaches LOCK_N → LOCKED, otherwise stay in MEASURE.
  - MEASURE, non-matching: `good`←0; no `Err`.
  - LOCKED, matching: stay in LOCKED.
  - LOCKED, non-matching (early tick, `cnt`<PERIOD): `Err` pulses, `ErrCnt`+1, `good`←0, go MEASURE.
- LOCKED, enabled non-tick cycle with `cnt`==PERIOD (missing tick): `Err` pulses, `ErrCnt`+1, `good`←0, go MEASURE. `cnt` keeps incrementing, so a late tick reports the long interval with no second `Err`.
- Enable low: `cnt`, state, `good` and `Tick` are all frozen or ignored; `PerValid` and `Err` stay low.
- `Resync`: go IDLE, `cnt`←0, `good`←0. `Period` and `ErrCnt` are held. `Resync` has priority over a same-cycle `Tick`; that tick is discarded.
- `ErrCnt` saturates at 15 and is cleared only by `Clear`.

## Timing
- `Clear` asserted: immediately (no clock needed) IDLE, `cnt`=0, `good`=0, and all outputs 0 (`Locked`, `Period`, `PerValid`, `Err`, `ErrCnt`). This holds even mid-period.
- All outputs are registered. `Period`, `PerValid`, `Err`, `ErrCnt` and `Locked` reflect a tick sampled at edge *k* immediately after edge *k*, with no further latency.
- `PerValid` and `Err` are high for exactly one cycle per event, even when `Enable` stays high.
- Generator ticks at enabled cycles 0 and 11 give `Period`=11. A continuous stream at PERIOD locks on the edge sampling tick LOCK_N+1.

## Test plan
(PERIOD=11, LOCK_N=3, CW=8)
- **Reset:** pulse `Clear` between edges → all outputs 0 with no clock edge. Apply 50 cycles with no `Tick` → still IDLE, no `Err`.
- **Lock acquisition:** ticks every 11 cycles with `Enable`=1 → `PerValid` with `Period`=11 after ticks 2, 3 and 4. `Locked` rises after tick 4; `Err` never asserts.
- **Missing tick while locked:** omit one tick → `Err` pulse on the edge where `cnt`==11, `ErrCnt`=1, `Locked`=0. The next tick reports `Period`=22 with no `Err`. Three more 11-cycle periods relock.
- **Early tick while locked:** tick 7 cycles after the previous one → `Period`=7, `Err` pulse, `ErrCnt`+1, `Locked`=0.
- **Enable stall:** drop `Enable` for 5 cycles mid-period while locked, generator also stalled → `Period` stays 11, `Locked` held, no `Err`. A `Tick` held high while `Enable`=0 is ignored.
- **Saturation and priority:** force 17 errors → `ErrCnt`=15. Assert `Resync` together with `Tick` → IDLE, `Locked`=0, no `PerValid`, `ErrCnt` still 15. Assert `Clear` mid-period → everything 0 at once.
